// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: PCSrc encodings, FSM states and
// default reset/trap vectors.
package pc_seq_pkg;

  // PCSrc encodings; any other code selects the sequential target.
  localparam logic [2:0] SRC_SEQ    = 3'b000;
  localparam logic [2:0] SRC_BRANCH = 3'b001;
  localparam logic [2:0] SRC_REG    = 3'b010;
  localparam logic [2:0] SRC_JUMP   = 3'b011;
  localparam logic [2:0] SRC_RET    = 3'b101;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_TRAPPED = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

  // A committed target must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_seq_ras.sv
// Circular return-address stack. A push on a full stack overwrites the
// oldest entry; pop on empty is ignored. Push and pop together replace the
// top entry. Only instantiated when PC_SEQ_RAS_EN is defined.
module pc_seq_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W:0]   cnt_q, cnt_d;

  // ptr_q is the next free slot; the top sits one below it (wrapping).
  assign top_idx = ptr_q - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_C);

  // Next stack contents, pointer and occupancy.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (pop && !empty && push) begin
      mem_d[top_idx] = push_data;
    end else if (pop && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - 1'b1;
    end else if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + 1'b1;
    end
  end

  // Pointer and count reset to an empty stack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage needs no reset: it is never read while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with misaligned-target trap FSM (RUN/TRAPPED).
// Optional return-address stack compiled in with `define PC_SEQ_RAS_EN;
// without it, return (101) behaves as register jump and ras_miss is 0.
// PCWrite is a one-cycle commit strobe: with state RUN and PCWrite=1 the
// selected target is taken at the next rising CLK edge; there is no stall.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR[WIDTH-1:0],
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR[WIDTH-1:0],
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWrite,
  input  logic [2:0]       PCSrc,
  input  logic [WIDTH-1:0] exten,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic             ras_push,
  input  logic             trap_ack,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC4,
  output logic [WIDTH-1:0] epc,
  output logic             trap,
  output logic             ras_miss,
  output pc_state_e        dbg_state
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             ras_miss_q, ras_miss_d;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ret_tgt;
  logic             ret_miss;
  logic             commit;

  assign PC4       = pc_q + WIDTH'(32'd4);
  assign PC        = pc_q;
  assign epc       = epc_q;
  assign trap      = (state_q == ST_TRAPPED);
  assign ras_miss  = ras_miss_q;
  assign dbg_state = state_q;

`ifdef PC_SEQ_RAS_EN
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             unused_ras_full;

  pc_seq_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst_n     (Reset),
    .push      (commit && ras_push),
    .pop       (commit && (PCSrc == SRC_RET)),
    .push_data (PC4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (unused_ras_full)
  );

  // Return target: stack top, or ReadData1 with a miss when empty.
  always_comb begin
    ret_tgt  = ras_empty ? ReadData1 : ras_top;
    ret_miss = ras_empty;
  end
`else
  logic unused_ras_push;
  localparam int UNUSED_RAS_DEPTH = RAS_DEPTH;
  assign unused_ras_push = ras_push;

  // Without a stack, return behaves as a register jump.
  always_comb begin
    ret_tgt  = ReadData1;
    ret_miss = 1'b0;
  end
`endif

  // Target mux; branch/reg/jump never depend on the stack.
  always_comb begin
    case (PCSrc)
      SRC_BRANCH: target = PC4 + exten;
      SRC_REG:    target = ReadData1;
      SRC_JUMP:   target = {PC4[WIDTH-1:WIDTH-4], exten[WIDTH-5:2], 2'b00};
      SRC_RET:    target = ret_tgt;
      default:    target = PC4;
    endcase
  end

  // FSM next state: commit target, trap on misalignment, leave on ack.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    ras_miss_d = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (PCWrite) begin
          ras_miss_d = (PCSrc == SRC_RET) && ret_miss;
          if (is_misaligned(target[1:0])) begin
            state_d = ST_TRAPPED;
            pc_d    = TRAP_VECTOR;
            epc_d   = pc_q;
          end else begin
            pc_d   = target;
            commit = 1'b1;
          end
        end
      end
      ST_TRAPPED: begin
        if (trap_ack) state_d = ST_RUN;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      ras_miss_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      ras_miss_q <= ras_miss_d;
    end
  end

endmodule
